multirotor_ctrl: RTL and testbench

Parametrised next-generation drone flight controller core. Takes altitude and two-axis direction commands through a valid/ready handshake and mixes them onto NMOT motors. Each motor setpoint is slew-rate limited, and the block sequences arm/spin-up/land through a state machine with a command watchdog. It sits between the command decoder and the per-motor PID loops; its rpm_set lanes feed the PID rpm_set inputs.

---
 rtl/multirotor_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_multirotor_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multirotor_ctrl.sv
// rtl/multirotor_ctrl.sv - multirotor command mixer, per-lane slew limiter and arm/land sequencer
//
// Purpose: mixes altitude and two-axis direction commands onto NMOT motor
// setpoints. Each setpoint is slew-limited. A DISARMED/SPINUP/FLY/LAND state
// machine sequences the motors.
// Optional feature macro: DRONECTRL_WDOG_EN adds a command watchdog that
// forces LAND when no command is accepted for TIMEOUT cycles in FLY.
//
// Ports:
//   clk        in   clock, all state on the rising edge
//   resetn     in   asynchronous active-low reset
//   arm        in   level arm request
//   cmd_valid  in   command valid
//   cmd_ready  out  command ready, (state == FLY) && arm
//   cmd_alt    in   signed 3-bit altitude command
//   cmd_lr     in   signed 3-bit lateral command, positive = right
//   cmd_fb     in   signed 3-bit longitudinal command, positive = forward
//   rpm_set    out  packed setpoints, motor i at [i*W +: W]
//   state      out  0 DISARMED, 1 SPINUP, 2 FLY, 3 LAND
module multirotor_ctrl #(
  parameter int NMOT     = 4,
  parameter int W        = 16,
  parameter int HOVER    = 4000,
  parameter int RPM_MAX  = 8000,
  parameter int ALT_GAIN = 512,
  parameter int DIR_GAIN = 256,
  parameter int STEP     = 500,
  parameter int TIMEOUT  = 100
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              arm,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_alt,
  input  logic [2:0]        cmd_lr,
  input  logic [2:0]        cmd_fb,
  output logic [NMOT*W-1:0] rpm_set,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_SPINUP   = 2'd1,
    ST_FLY      = 2'd2,
    ST_LAND     = 2'd3
  } state_e;

  // Five guard bits above W hold the signed mix without wrap.
  localparam int TW = W + 5;
  localparam logic signed [TW-1:0] HOVER_S = TW'(HOVER);
  localparam logic signed [TW-1:0] MAX_S   = TW'(RPM_MAX);
  localparam logic signed [TW-1:0] ALT_S   = TW'(ALT_GAIN);
  localparam logic signed [TW-1:0] DIR_S   = TW'(DIR_GAIN);
  localparam logic [W-1:0]         HOVER_W = W'(HOVER);
  localparam logic [W-1:0]         MAX_W   = W'(RPM_MAX);
  localparam logic [W-1:0]         STEP_W  = W'(STEP);

  if ((NMOT % 4) != 0 || NMOT < 4 || RPM_MAX >= (1 << W) || STEP < 1 || TIMEOUT < 1)
  begin : g_bad_params
    $error("multirotor_ctrl: illegal parameter set");
  end

  state_e state_q, state_d;
  logic [W-1:0] rpm_q [NMOT];
  logic [W-1:0] rpm_d [NMOT];
  logic [W-1:0] tgt   [NMOT];
  logic signed [2:0] alt_q, alt_d, lr_q, lr_d, fb_q, fb_d;
  logic signed [TW-1:0] base, dir_lr, dir_fb, raw;
  logic accept, all_hover, all_zero, wdog_expire;

  assign cmd_ready = (state_q == ST_FLY) && arm;
  assign accept    = cmd_valid && cmd_ready;
  assign state     = state_q;

  for (genvar g = 0; g < NMOT; g++) begin : g_pack
    assign rpm_set[g*W +: W] = rpm_q[g];
  end

  // Mixer and clamp, then slew toward the target.
  always_comb begin
    base      = HOVER_S + {{(TW-3){alt_q[2]}}, alt_q} * ALT_S;
    dir_lr    = {{(TW-3){lr_q[2]}}, lr_q} * DIR_S;
    dir_fb    = {{(TW-3){fb_q[2]}}, fb_q} * DIR_S;
    raw       = '0;
    all_hover = 1'b1;
    all_zero  = 1'b1;
    for (int i = 0; i < NMOT; i++) begin
      case (i % 4)
        0:       raw = base + dir_lr;
        1:       raw = base - dir_lr;
        2:       raw = base - dir_fb;
        default: raw = base + dir_fb;
      endcase
      case (state_q)
        ST_SPINUP: tgt[i] = HOVER_W;
        ST_FLY: begin
          if (raw[TW-1])       tgt[i] = '0;
          else if (raw > MAX_S) tgt[i] = MAX_W;
          else                  tgt[i] = raw[W-1:0];
        end
        default:   tgt[i] = '0;
      endcase
      if (tgt[i] > rpm_q[i])
        rpm_d[i] = (tgt[i] - rpm_q[i] > STEP_W) ? rpm_q[i] + STEP_W : tgt[i];
      else
        rpm_d[i] = (rpm_q[i] - tgt[i] > STEP_W) ? rpm_q[i] - STEP_W : tgt[i];
      if (rpm_q[i] != HOVER_W) all_hover = 1'b0;
      if (rpm_q[i] != '0)      all_zero  = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_DISARMED: if (arm) state_d = ST_SPINUP;
      ST_SPINUP: begin
        if (!arm)           state_d = ST_LAND;
        else if (all_hover) state_d = ST_FLY;
      end
      ST_FLY:      if (!arm || wdog_expire) state_d = ST_LAND;
      default:     if (all_zero) state_d = ST_DISARMED;
    endcase
  end

  always_comb begin
    alt_d = alt_q;
    lr_d  = lr_q;
    fb_d  = fb_q;
    if (accept) begin
      alt_d = cmd_alt;
      lr_d  = cmd_lr;
      fb_d  = cmd_fb;
    end else if (state_d == ST_LAND && state_q != ST_LAND) begin
      alt_d = '0;
      lr_d  = '0;
      fb_d  = '0;
    end
  end

`ifdef DRONECTRL_WDOG_EN
  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  logic [WDW-1:0] wdog_q, wdog_d;

  // An accept on the expiry cycle wins, so expiry is masked by accept.
  assign wdog_expire = (wdog_q == WD_LAST) && !accept;

  always_comb begin
    wdog_d = wdog_q;
    if (accept || state_d != state_q)
      wdog_d = '0;
    else if (state_q == ST_FLY && wdog_q != WD_LAST)
      wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wdog_q <= '0;
    else         wdog_q <= wdog_d;
  end
`else
  assign wdog_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_DISARMED;
      alt_q   <= '0;
      lr_q    <= '0;
      fb_q    <= '0;
      for (int i = 0; i < NMOT; i++) rpm_q[i] <= '0;
    end else begin
      state_q <= state_d;
      alt_q   <= alt_d;
      lr_q    <= lr_d;
      fb_q    <= fb_d;
      for (int i = 0; i < NMOT; i++) rpm_q[i] <= rpm_d[i];
    end
  end

endmodule

// File: tb/tb_multirotor_ctrl.sv
// tb/tb_multirotor_ctrl.sv - self-checking bench for multirotor_ctrl
module tb_multirotor_ctrl;

`ifdef DRONECTRL_WDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int ALT = 512, DIR = 256, STP = 500, TO = 100;

  logic clk = 1'b0;
  logic resetn;
  logic arm [2];
  logic valid [2];
  logic [2:0] alt [2];
  logic [2:0] lr [2];
  logic [2:0] fb [2];
  logic ready [2];
  logic [63:0] rpm [2];
  logic [1:0] st [2];

  always #5 clk = ~clk;

  multirotor_ctrl u_a (
    .clk(clk), .resetn(resetn), .arm(arm[0]), .cmd_valid(valid[0]), .cmd_ready(ready[0]),
    .cmd_alt(alt[0]), .cmd_lr(lr[0]), .cmd_fb(fb[0]), .rpm_set(rpm[0]), .state(st[0])
  );

  multirotor_ctrl #(.HOVER(1000), .RPM_MAX(3000)) u_b (
    .clk(clk), .resetn(resetn), .arm(arm[1]), .cmd_valid(valid[1]), .cmd_ready(ready[1]),
    .cmd_alt(alt[1]), .cmd_lr(lr[1]), .cmd_fb(fb[1]), .rpm_set(rpm[1]), .state(st[1])
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: whole-number arithmetic on the documented rules.
  int p_hover [2] = '{4000, 1000};
  int p_max   [2] = '{8000, 3000};
  int m_st [2];
  int m_rpm [2][4];
  int m_alt [2], m_lr [2], m_fb [2], m_wd [2];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane(input int k, input int i);
    return int'(rpm[k][i*16 +: 16]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_alt[k] = 0; m_lr[k] = 0; m_fb[k] = 0; m_wd[k] = 0;
      for (int i = 0; i < 4; i++) m_rpm[k][i] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int t [4];
    int ns, base, d;
    bit acc, allh, allz;
    acc  = valid[k] && arm[k] && (m_st[k] == 2);
    base = p_hover[k] + m_alt[k] * ALT;
    allh = 1'b1;
    allz = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (m_st[k] == 1) t[i] = p_hover[k];
      else if (m_st[k] == 2) begin
        case (i)
          0: t[i] = base + m_lr[k] * DIR;
          1: t[i] = base - m_lr[k] * DIR;
          2: t[i] = base - m_fb[k] * DIR;
          default: t[i] = base + m_fb[k] * DIR;
        endcase
        if (t[i] < 0) t[i] = 0;
        if (t[i] > p_max[k]) t[i] = p_max[k];
      end else t[i] = 0;
      if (m_rpm[k][i] != p_hover[k]) allh = 1'b0;
      if (m_rpm[k][i] != 0) allz = 1'b0;
    end
    case (m_st[k])
      0: ns = arm[k] ? 1 : 0;
      1: ns = !arm[k] ? 3 : (allh ? 2 : 1);
      2: ns = (!arm[k] || (WD && m_wd[k] == TO - 1 && !acc)) ? 3 : 2;
      default: ns = allz ? 0 : 3;
    endcase
    for (int i = 0; i < 4; i++) begin
      d = t[i] - m_rpm[k][i];
      if (d > STP) d = STP;
      if (d < -STP) d = -STP;
      m_rpm[k][i] = m_rpm[k][i] + d;
    end
    if (acc) begin
      m_alt[k] = $signed(alt[k]);
      m_lr[k]  = $signed(lr[k]);
      m_fb[k]  = $signed(fb[k]);
    end else if (ns == 3 && m_st[k] != 3) begin
      m_alt[k] = 0; m_lr[k] = 0; m_fb[k] = 0;
    end
    if (acc || ns != m_st[k]) m_wd[k] = 0;
    else if (m_st[k] == 2 && m_wd[k] < TO - 1) m_wd[k] = m_wd[k] + 1;
    m_st[k] = ns;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("m%0d.state", k), int'(st[k]), m_st[k]);
      check($sformatf("m%0d.ready", k), int'(ready[k]), (m_st[k] == 2 && arm[k]) ? 1 : 0);
      for (int i = 0; i < 4; i++)
        check($sformatf("m%0d.lane%0d", k, i), lane(k, i), m_rpm[k][i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    compare_all();
  endtask

  task automatic wait_disarm(input int k, input string name);
    for (int n = 0; n < 40; n++) begin
      if (st[k] == 2'd0) break;
      step();
    end
    check(name, int'(st[k]), 0);
  endtask

  typedef struct {
    bit arm, valid;
    int alt, lr, fb;
    int e_st, e_rdy, e0, e1, e2, e3;
  } vec_t;

  vec_t tbl [14];

  initial begin : main
    // Spin-up and first command, expectations taken from the documented timing.
    for (int j = 0; j < 10; j++) begin
      tbl[j] = '{1'b1, 1'b0, 0, 0, 0, (j == 9) ? 2 : 1, (j == 9) ? 1 : 0,
                 (j == 9) ? 4000 : 500*j, (j == 9) ? 4000 : 500*j,
                 (j == 9) ? 4000 : 500*j, (j == 9) ? 4000 : 500*j};
    end
    tbl[10] = '{1'b1, 1'b1, 2, 1, 0, 2, 1, 4000, 4000, 4000, 4000};
    tbl[11] = '{1'b1, 1'b0, 0, 0, 0, 2, 1, 4500, 4500, 4500, 4500};
    tbl[12] = '{1'b1, 1'b0, 0, 0, 0, 2, 1, 5000, 4768, 5000, 5000};
    tbl[13] = '{1'b1, 1'b0, 0, 0, 0, 2, 1, 5280, 4768, 5024, 5024};

    for (int k = 0; k < 2; k++) begin
      arm[k] = 1'b0; valid[k] = 1'b1; alt[k] = 3'd0; lr[k] = 3'd0; fb[k] = 3'd0;
    end
    resetn = 1'b0;
    model_reset();
    #12;
    check("rst.state", int'(st[0]), 0);
    check("rst.ready", int'(ready[0]), 0);
    check("rst.rpm", int'(rpm[0][31:0]), 0);
    compare_all();
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) step();
    check("idle.no_accept", int'(st[0]), 0);
    valid[0] = 1'b0;
    valid[1] = 1'b0;

    for (int j = 0; j < 14; j++) begin
      arm[0]   = tbl[j].arm;
      valid[0] = tbl[j].valid;
      alt[0]   = 3'(tbl[j].alt);
      lr[0]    = 3'(tbl[j].lr);
      fb[0]    = 3'(tbl[j].fb);
      step();
      check($sformatf("tbl%0d.state", j), int'(st[0]), tbl[j].e_st);
      check($sformatf("tbl%0d.ready", j), int'(ready[0]), tbl[j].e_rdy);
      check($sformatf("tbl%0d.left", j), lane(0, 0), tbl[j].e0);
      check($sformatf("tbl%0d.right", j), lane(0, 1), tbl[j].e1);
      check($sformatf("tbl%0d.front", j), lane(0, 2), tbl[j].e2);
      check($sformatf("tbl%0d.rear", j), lane(0, 3), tbl[j].e3);
    end
    valid[0] = 1'b0;

    // Watchdog: accept was 3 edges ago, expiry 100 edges after the accept.
    repeat (96) step();
    check("wd.before_expiry", int'(st[0]), 2);
    step();
    check("wd.expiry", int'(st[0]), WD ? 3 : 2);
    arm[0] = 1'b0;
    wait_disarm(0, "wd.disarm");

    // Accept on the expiry cycle keeps FLY.
    arm[0] = 1'b1;
    repeat (10) step();
    check("wd2.fly", int'(st[0]), 2);
    repeat (99) step();
    valid[0] = 1'b1; alt[0] = 3'd1; lr[0] = 3'd0; fb[0] = 3'b111;
    step();
    valid[0] = 1'b0;
    check("wd2.accept_wins", int'(st[0]), 2);
    repeat (99) step();
    check("wd2.before_expiry", int'(st[0]), 2);
    step();
    check("wd2.expiry", int'(st[0]), WD ? 3 : 2);
    arm[0] = 1'b0;
    wait_disarm(0, "wd2.disarm");

    // Drop arm during spin-up.
    arm[0] = 1'b1;
    repeat (4) step();
    arm[0] = 1'b0;
    step();
    check("drop.state", int'(st[0]), 3);
    check("drop.lane", lane(0, 0), 2000);
    for (int v = 1500; v >= 0; v -= 500) begin
      step();
      check("drop.land_state", int'(st[0]), 3);
      check("drop.land_lane", lane(0, 2), v);
    end
    step();
    check("drop.disarmed", int'(st[0]), 0);

    // Clamp on the low-hover instance.
    arm[1] = 1'b1;
    repeat (4) step();
    check("clamp.fly", int'(st[1]), 2);
    valid[1] = 1'b1; alt[1] = 3'd3; lr[1] = 3'd3; fb[1] = 3'd0;
    step();
    valid[1] = 1'b0;
    repeat (8) step();
    check("clamp.left_hi", lane(1, 0), 3000);
    check("clamp.right", lane(1, 1), 1768);
    check("clamp.front", lane(1, 2), 2536);
    valid[1] = 1'b1; alt[1] = 3'b100; lr[1] = 3'b101; fb[1] = 3'd0;
    step();
    valid[1] = 1'b0;
    repeat (8) step();
    check("clamp.right_lo", lane(1, 1), 0);
    check("clamp.left_lo", lane(1, 0), 0);
    arm[1] = 1'b0;
    wait_disarm(1, "clamp.disarm");

    // Asynchronous reset in FLY.
    arm[0] = 1'b1;
    repeat (10) step();
    check("arst.fly", int'(st[0]), 2);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("arst.rpm", int'(rpm[0][31:0]), 0);
    check("arst.state", int'(st[0]), 0);
    check("arst.ready", int'(ready[0]), 0);
    arm[0] = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(39) == 0) arm[k] = ~arm[k];
        valid[k] = (c < 1500) ? ($urandom_range(2) == 0) : ($urandom_range(199) == 0);
        alt[k] = 3'($urandom);
        lr[k]  = 3'($urandom);
        fb[k]  = 3'($urandom);
      end
      step();
      if (c % 997 == 500) begin
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        compare_all();
        #1;
        resetn = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : guard
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule
